// File: rtl/seq_det_pkg.sv
// Shared limits, reset defaults and helpers for the parametrised Mealy sequence detector.
package seq_det_pkg;

    localparam int PAT_LEN_MIN     = 2;
    localparam int PAT_LEN_MAX     = 32;
    localparam int DEFAULT_PAT_LEN = 3;

    localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 3'b101;
    localparam logic                       DEFAULT_OVERLAP = 1'b1;

    // What the current cycle does to the detector state.
    typedef enum logic [1:0] {
        EV_IDLE,
        EV_LOAD,
        EV_MISS,
        EV_HIT
    } bit_event_e;

    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != '1)) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mealy_seq_det.sv
// Parametrised serial-pattern Mealy detector with valid-qualified input and runtime pattern/overlap.
// Optional saturating match counter enabled by defining MEALY_SEQ_DET_CNT_EN.
module mealy_seq_det
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN     = DEFAULT_PAT_LEN,
    parameter logic [PAT_LEN-1:0] DEF_PATTERN = PAT_LEN'(DEFAULT_PATTERN),
    parameter logic               DEF_OVERLAP = DEFAULT_OVERLAP,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               I,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               det,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int                FILL_W    = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

    generate
        if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_pat_len
            $error("mealy_seq_det: PAT_LEN must lie in 2..32");
        end
    endgenerate

    logic [PAT_LEN-1:0] pat_reg,  pat_next;
    logic               ovl_reg,  ovl_next;
    logic [PAT_LEN-2:0] hist_reg, hist_next;
    logic [FILL_W-1:0]  fill_reg, fill_next;

    logic [PAT_LEN-1:0] window;
    logic [PAT_LEN-1:0] bit_match;
    logic               full;
    logic               window_match;
    bit_event_e         bit_event;

    // The candidate window is the buffered history plus the bit on the wire now.
    assign window = {hist_reg, I};
    assign full   = (fill_reg == FILL_FULL);

    genvar gi;
    generate
        for (gi = 0; gi < PAT_LEN; gi++) begin : g_bit_cmp
            assign bit_match[gi] = ~(window[gi] ^ pat_reg[gi]);
        end
    endgenerate

    assign window_match = &bit_match;

    always_comb begin
        bit_event = EV_IDLE;
        if (cfg_load) begin
            bit_event = EV_LOAD;
        end else if (in_valid) begin
            bit_event = (full && window_match) ? EV_HIT : EV_MISS;
        end
    end

    assign det = (bit_event == EV_HIT);

    always_comb begin
        pat_next  = pat_reg;
        ovl_next  = ovl_reg;
        hist_next = hist_reg;
        fill_next = fill_reg;
        case (bit_event)
            EV_LOAD: begin
                pat_next  = cfg_pattern;
                ovl_next  = cfg_overlap;
                hist_next = '0;
                fill_next = '0;
            end
            EV_MISS: begin
                hist_next = window[PAT_LEN-2:0];
                if (!full) begin
                    fill_next = fill_reg + FILL_W'(1);
                end
            end
            EV_HIT: begin
                // Overlap keeps the suffix so it can seed the next match; otherwise start afresh.
                if (ovl_reg) begin
                    hist_next = window[PAT_LEN-2:0];
                end else begin
                    hist_next = '0;
                    fill_next = '0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg  <= DEF_PATTERN;
            ovl_reg  <= DEF_OVERLAP;
            hist_reg <= '0;
            fill_reg <= '0;
        end else begin
            pat_reg  <= pat_next;
            ovl_reg  <= ovl_next;
            hist_reg <= hist_next;
            fill_reg <= fill_next;
        end
    end

`ifdef MEALY_SEQ_DET_CNT_EN
    sat_counter #(
        .WIDTH(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (det),
        .clr   (cnt_clr),
        .count (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: doc/mealy_seq_det.md
Name: mealy_seq_det

Overview:
- Parametrised serial-pattern Mealy detector, successor to the fixed 3-bit "101" detector.
- Pattern length is set at elaboration; pattern bits and overlap mode are programmable at runtime.
- Input bits are qualified by a valid strobe, so the block can sit behind stalling serial sources such as UART or SPI bit streams.
- Drives a same-cycle Mealy detect pulse and, optionally, a saturating match counter.

Parameters:
- PAT_LEN, 3, pattern length in bits; legal range 2..32.
- DEF_PATTERN, 3'b101, pattern value loaded at reset; MSB is the first bit received.
- DEF_OVERLAP, 1, overlap mode at reset (1 = overlapping matches allowed).
- CNT_W, 8, match counter width; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  I is sampled this cycle.
- I  input  1  serial data bit.
- cfg_load  input  1  load cfg_pattern and cfg_overlap this cycle.
- cfg_pattern  input  PAT_LEN  new pattern; MSB is the first bit received.
- cfg_overlap  input  1  new overlap mode.
- cnt_clr  input  1  synchronous clear of match_cnt.
- det  output  1  Mealy detect; combinational from state and inputs.
- match_cnt  output  CNT_W  saturating number of detects.

Behaviour:
- Reset (rst=0, asynchronous):
  - pat_q=DEF_PATTERN, ovl_q=DEF_OVERLAP.
  - hist_q (PAT_LEN-1 bits)=0, fill_q=0.
  - match_cnt=0.
  - det=0, because fill_q=0 forces a miss.
- State: fill_q counts valid bits held in hist_q, 0..PAT_LEN-1, saturating. It is the Mealy state, with S0..S(PAT_LEN-1) meaning "k bits buffered".
- det = in_valid & ~cfg_load & (fill_q==PAT_LEN-1) & ({hist_q,I}==pat_q). Latency is zero: det is asserted in the same cycle as the last pattern bit.
- Accepted bit (in_valid=1, cfg_load=0):
  - Miss: hist_q<={hist_q[PAT_LEN-3:0],I}; fill_q<=min(fill_q+1, PAT_LEN-1).
  - Hit with ovl_q=1: history shifts as on a miss, fill_q stays PAT_LEN-1, so the pattern suffix can start the next match.
  - Hit with ovl_q=0: hist_q<=0, fill_q<=0; the next match needs PAT_LEN fresh bits.
- in_valid=0: state holds, det=0.
- cfg_load=1:
  - pat_q<=cfg_pattern, ovl_q<=cfg_overlap, hist_q<=0, fill_q<=0.
  - Any bit presented in the same cycle is dropped and det=0; cfg_load has priority over in_valid.
  - match_cnt is unaffected.
- Mid-stream reset: the asynchronous reset aborts any partial match immediately. The first detect after deassertion needs PAT_LEN accepted bits.
- match_cnt (feature enabled):
  - Increments on det, saturating at 2^CNT_W-1.
  - cnt_clr has priority: cnt_clr and det in the same cycle give match_cnt=0.
- PAT_LEN outside 2..32 is an elaboration error; the block fails elaboration.

Optional Feature:
- Macro: MEALY_SEQ_DET_CNT_EN.
- Defined: match counter as described above.
- Undefined: no counter flops; match_cnt tied to 0; cnt_clr ignored. Port list is identical in both builds.

Decomposition:
- Package seq_det_pkg holds:
  - min/max PAT_LEN limits;
  - the default pattern/overlap constants;
  - a function to compute the fill counter width, $clog2(PAT_LEN).
- One natural sub-module: sat_counter (parametrised width; inc, clr with clr priority, saturate). Instantiated only under MEALY_SEQ_DET_CNT_EN.

Test Plan:
- Defaults (101, overlap), continuous valid, bits 1,0,1,0,1 -> det=1 on the 3rd and 5th bits only; match_cnt=2.
- cfg_load pattern=101, overlap=0, then bits 1,0,1,0,1 -> det only on the 3rd bit; match_cnt increments by 1.
- Bits 1,0,1 with in_valid low for 3 cycles between each bit, I toggling during gaps -> single det on the 3rd valid bit; no det during gaps.
- PAT_LEN=4, load 1101: stream 1,1,0,1,1,0,1 with overlap=1 -> det on the 4th and 7th bits. Assert cfg_load together with the last bit of a would-be match -> det=0, fill_q=0.
- Reset mid-stream after bits 1,0 (pattern 101), then bit 1 -> det=0; det appears only after a fresh 1,0,1.
- CNT_W=2 with macro defined, 5 overlapping 101 hits -> match_cnt saturates at 3. cnt_clr in the same cycle as a hit -> match_cnt=0.
